// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: single-cycle ALU, destination/store-data select,
// HI/LO registers and a 32-cycle iterative multiply/divide unit with hazard stall.
module ex_stage (
   input  logic        clock,
   input  logic        reset,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic        MemWriteE,
   input  logic [4:0]  ALUControlE,
   input  logic        ALUSrcE,
   input  logic        RegDstE,
   input  logic [31:0] SrcAE,
   input  logic [31:0] Readdata2E,
   input  logic [31:0] ImmE,
   input  logic [4:0]  RtE,
   input  logic [4:0]  RdE,
   output logic [31:0] ALUOutE,
   output logic [31:0] WriteDataE,
   output logic [4:0]  WriteRegE,
   output logic        RegWriteXE,
   output logic        MemWriteXE,
   output logic        MemtoRegXE,
   output logic        StallE,
   output logic        MdBusy
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

   md_state_t   state;
   logic [4:0]  count;
   logic        is_div;
   logic        neg_q;
   logic        neg_r;
   logic        div_zero;
   logic [31:0] dividend;
   logic [31:0] operand;
   logic [63:0] acc;
   logic [31:0] hi;
   logic [31:0] lo;

   logic [31:0] src_b;
   logic [4:0]  sa;
   logic        is_hilo;
   logic        is_md;
   logic        is_signed;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [64:0] div_shift;
   logic [32:0] div_trial;
   logic [63:0] div_next;
   logic [63:0] step_acc;
   logic [63:0] prod;

   assign src_b      = ALUSrcE ? ImmE : Readdata2E;
   assign sa         = ImmE[10:6];
   assign is_hilo    = (ALUControlE >= 5'd15) && (ALUControlE <= 5'd22);
   assign is_md      = (ALUControlE >= 5'd15) && (ALUControlE <= 5'd18);
   assign is_signed  = (ALUControlE == 5'd15) || (ALUControlE == 5'd17);
   assign MdBusy     = (state == BUSY);
   assign StallE     = MdBusy & is_hilo;
   assign WriteDataE = Readdata2E;
   assign WriteRegE  = RegDstE ? RdE : RtE;
   assign RegWriteXE = RegWriteE & ~StallE;
   assign MemWriteXE = MemWriteE & ~StallE;
   assign MemtoRegXE = MemtoRegE & ~StallE;

   // Signed operations iterate on magnitudes; signs are restored when the result is written
   assign mag_a = (is_signed && SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;
   assign mag_b = (is_signed && src_b[31]) ? (32'd0 - src_b) : src_b;

   // One shift-add step (multiplier in acc[31:0]) and one restoring-divide step (rem:quot in acc)
   assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
   assign mul_next  = {mul_sum, acc[31:1]};
   assign div_shift = {acc, 1'b0};
   assign div_trial = div_shift[64:32] - {1'b0, operand};
   assign div_next  = div_trial[32] ? div_shift[63:0] : {div_trial[31:0], div_shift[31:1], 1'b1};
   assign step_acc  = is_div ? div_next : mul_next;
   assign prod      = neg_q ? (64'd0 - step_acc) : step_acc;

   // Combinational ALU result
   always_comb begin
      ALUOutE = 32'd0;
      case (ALUControlE)
         5'd0:  ALUOutE = SrcAE + src_b;
         5'd1:  ALUOutE = SrcAE - src_b;
         5'd2:  ALUOutE = SrcAE & src_b;
         5'd3:  ALUOutE = SrcAE | src_b;
         5'd4:  ALUOutE = SrcAE ^ src_b;
         5'd5:  ALUOutE = ~(SrcAE | src_b);
         5'd6:  ALUOutE = {31'd0, ($signed(SrcAE) < $signed(src_b))};
         5'd7:  ALUOutE = {31'd0, (SrcAE < src_b)};
         5'd8:  ALUOutE = src_b << sa;
         5'd9:  ALUOutE = src_b >> sa;
         5'd10: ALUOutE = $signed(src_b) >>> sa;
         5'd11: ALUOutE = src_b << SrcAE[4:0];
         5'd12: ALUOutE = src_b >> SrcAE[4:0];
         5'd13: ALUOutE = $signed(src_b) >>> SrcAE[4:0];
         5'd14: ALUOutE = {src_b[15:0], 16'h0000};
         5'd19: ALUOutE = hi;
         5'd20: ALUOutE = lo;
         default: ALUOutE = 32'd0;
      endcase
   end

   // Mul/div FSM, iteration datapath and HI/LO registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         count    <= 5'd0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         dividend <= 32'd0;
         operand  <= 32'd0;
         acc      <= 64'd0;
         hi       <= 32'd0;
         lo       <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (is_md) begin
                  state    <= BUSY;
                  count    <= 5'd31;
                  is_div   <= (ALUControlE == 5'd17) || (ALUControlE == 5'd18);
                  neg_q    <= is_signed & (SrcAE[31] ^ src_b[31]);
                  neg_r    <= is_signed & SrcAE[31];
                  div_zero <= (src_b == 32'd0);
                  dividend <= SrcAE;
                  operand  <= mag_b;
                  acc      <= {32'd0, mag_a};
               end else if (ALUControlE == 5'd21) begin
                  hi <= SrcAE;
               end else if (ALUControlE == 5'd22) begin
                  lo <= SrcAE;
               end else begin
                  state <= IDLE;
               end
            end
            BUSY: begin
               acc   <= step_acc;
               count <= count - 5'd1;
               if (count == 5'd0) begin
                  state <= IDLE;
                  if (!is_div) begin
                     hi <= prod[63:32];
                     lo <= prod[31:0];
                  end else if (div_zero) begin
                     hi <= dividend;
                     lo <= 32'hFFFF_FFFF;
                  end else begin
                     lo <= neg_q ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
                     hi <= neg_r ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
                  end
               end else begin
                  state <= BUSY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed and random ALU/mul-div stimulus against a
// behavioural model built on 64-bit arithmetic and a cycle-count view of HI/LO availability.
module tb_ex_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        RegWriteE, MemtoRegE, MemWriteE;
   logic [4:0]  ALUControlE;
   logic        ALUSrcE, RegDstE;
   logic [31:0] SrcAE, Readdata2E, ImmE;
   logic [4:0]  RtE, RdE;
   logic [31:0] ALUOutE, WriteDataE;
   logic [4:0]  WriteRegE;
   logic        RegWriteXE, MemWriteXE, MemtoRegXE, StallE, MdBusy;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;
   int ready_cyc = 0;
   logic [31:0] hi_m = 32'd0;
   logic [31:0] lo_m = 32'd0;

   ex_stage dut (
      .clock(clock), .reset(reset),
      .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
      .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
      .SrcAE(SrcAE), .Readdata2E(Readdata2E), .ImmE(ImmE), .RtE(RtE), .RdE(RdE),
      .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
      .RegWriteXE(RegWriteXE), .MemWriteXE(MemWriteXE), .MemtoRegXE(MemtoRegXE),
      .StallE(StallE), .MdBusy(MdBusy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] s);
      case (op)
         5'd0:  return a + b;
         5'd1:  return a - b;
         5'd2:  return a & b;
         5'd3:  return a | b;
         5'd4:  return a ^ b;
         5'd5:  return ~(a | b);
         5'd6:  return (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
         5'd7:  return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
         5'd8:  return b << s;
         5'd9:  return b >> s;
         5'd10: return 32'(longint'($signed(b)) / (longint'(1) << s)
                           - ((b[31] && ((b & ((32'd1 << s) - 32'd1)) != 32'd0)) ? 1 : 0));
         5'd11: return b << a[4:0];
         5'd12: return b >> a[4:0];
         5'd13: return alu_ref(5'd10, 32'd0, b, a[4:0]);
         5'd14: return {b[15:0], 16'h0000};
         5'd19: return hi_m;
         5'd20: return lo_m;
         default: return 32'd0;
      endcase
   endfunction

   // Returns {HI, LO} for a mul/div using plain wide arithmetic.
   function automatic logic [63:0] md_ref(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa_, sb_, q, r;
      longint unsigned ua, ub;
      logic [63:0] res;
      sa_ = longint'($signed(a));
      sb_ = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      res = 64'd0;
      case (op)
         5'd15: res = sa_ * sb_;
         5'd16: res = ua * ub;
         5'd17, 5'd18: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else if (op == 5'd17) begin
               q = sa_ / sb_;
               r = sa_ % sb_;
               res = {r[31:0], q[31:0]};
            end else begin
               res = {32'(ua % ub), 32'(ua / ub)};
            end
         end
         default: res = 64'd0;
      endcase
      return res;
   endfunction

   task automatic bubble();
      ALUControlE = 5'd0; RegWriteE = 1'b0; MemWriteE = 1'b0; MemtoRegE = 1'b0;
      SrcAE = 32'd0; Readdata2E = 32'd0; ALUSrcE = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic alu_case(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] rd2, input logic [31:0] imm, input logic alusrc,
                           input logic regdst, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [2:0] ctl, input logic [31:0] exp);
      ALUControlE = op; SrcAE = a; Readdata2E = rd2; ImmE = imm; ALUSrcE = alusrc;
      RegDstE = regdst; RtE = rt; RdE = rd;
      {RegWriteE, MemWriteE, MemtoRegE} = ctl;
      #4;
      check(tag, ALUOutE, exp);
      check({tag, "_side"}, {WriteDataE, WriteRegE, RegWriteXE, MemWriteXE, MemtoRegXE},
            {rd2, (regdst ? rd : rt), ctl});
      @(posedge clock); #1;
   endtask

   // Issues one instruction (B from Readdata2E), waits out any stall, checks result and timing.
   task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      int exp_st, st;
      logic gbad;
      logic [31:0] res;
      logic rw;
      logic [63:0] p;
      exp_st = (op >= 5'd15 && op <= 5'd22 && ready_cyc > cyc) ? ready_cyc - cyc : 0;
      ALUControlE = op; SrcAE = a; Readdata2E = b; ALUSrcE = 1'b0; ImmE = 32'd0;
      RegWriteE = 1'b1; MemWriteE = 1'b1; MemtoRegE = 1'b1;
      st = 0; gbad = 1'b0;
      #4;
      while (StallE === 1'b1 && st < 40) begin
         if ({RegWriteXE, MemWriteXE, MemtoRegXE} !== 3'b000) gbad = 1'b1;
         st++;
         @(posedge clock); #5;
      end
      res = ALUOutE;
      rw  = RegWriteXE;
      @(posedge clock); #1;
      check({tag, "_stall"}, st, exp_st);
      check({tag, "_out"}, res, alu_ref(op, a, b, 5'd0));
      check({tag, "_ctl"}, {gbad, rw}, 2'b01);
      if (op >= 5'd15 && op <= 5'd18) begin
         p = md_ref(op, a, b);
         hi_m = p[63:32];
         lo_m = p[31:0];
         ready_cyc = cyc + 32;
      end else if (op == 5'd21) hi_m = a;
      else if (op == 5'd22) lo_m = a;
   endtask

   initial begin
      logic [4:0] op;
      logic [31:0] a, b, imm;
      logic alusrc;
      reset = 1'b1;
      RegWriteE = 1'b0; MemWriteE = 1'b0; MemtoRegE = 1'b0; ALUControlE = 5'd19;
      ALUSrcE = 1'b0; RegDstE = 1'b0; SrcAE = 32'd0; Readdata2E = 32'd0; ImmE = 32'd0;
      RtE = 5'd0; RdE = 5'd0;
      #3;
      check("reset_busy", {MdBusy, StallE}, 2'b00);
      check("reset_hi", ALUOutE, 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      do_op("reset_lo", 5'd20, 32'd0, 32'd0);

      // Directed ALU sweep
      alu_case("add",  5'd0,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd3, 5'd9, 3'b100, 32'd0);
      alu_case("sub",  5'd1,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd3, 5'd9, 3'b010, 32'hFFFF_FFFE);
      alu_case("slt",  5'd6,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 5'd4, 5'd31, 3'b001, 32'd1);
      alu_case("sltu", 5'd7,  32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 5'd4, 5'd31, 3'b111, 32'd0);
      alu_case("sra",  5'd10, 32'd0, 32'h8000_0000, 32'd4 << 6, 1'b0, 1'b0, 5'd1, 5'd2, 3'b100, 32'hF800_0000);
      alu_case("lui",  5'd14, 32'd0, 32'd7, 32'h0000_1234, 1'b1, 1'b0, 5'd1, 5'd2, 3'b100, 32'h1234_0000);
      alu_case("none", 5'd27, 32'h1111_1111, 32'd5, 32'd0, 1'b0, 1'b0, 5'd1, 5'd2, 3'b100, 32'd0);

      // Random ALU ops outside the HI/LO class
      for (int i = 0; i < 30; i++) begin
         op = 5'($urandom_range(0, 23));
         if (op > 5'd14) op = op + 5'd8;
         a = $urandom; b = $urandom; imm = $urandom; alusrc = 1'($urandom);
         alu_case("rand_alu", op, a, b, imm, alusrc, 1'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), alu_ref(op, a, alusrc ? imm : b, imm[10:6]));
      end

      // MULT -7 x 3 with an immediate MFLO
      do_op("mult", 5'd15, 32'hFFFF_FFF9, 32'd3);
      do_op("mflo_mult", 5'd20, 32'd0, 32'd0);
      check("mflo_mult_val", lo_m, 32'hFFFF_FFEB);
      do_op("mfhi_mult", 5'd19, 32'd0, 32'd0);
      check("mfhi_mult_val", hi_m, 32'hFFFF_FFFF);

      // Divides including the boundary cases
      do_op("div", 5'd17, 32'hFFFF_FFF9, 32'd2);
      do_op("mflo_div", 5'd20, 32'd0, 32'd0);
      do_op("mfhi_div", 5'd19, 32'd0, 32'd0);
      check("div_vals", {hi_m, lo_m}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      do_op("divu0", 5'd18, 32'd7, 32'd0);
      do_op("mflo_divu0", 5'd20, 32'd0, 32'd0);
      do_op("mfhi_divu0", 5'd19, 32'd0, 32'd0);
      check("divu0_vals", {hi_m, lo_m}, {32'd7, 32'hFFFF_FFFF});
      do_op("div0", 5'd17, 32'hFFFF_FFF8, 32'd0);
      do_op("mfhi_div0", 5'd19, 32'd0, 32'd0);
      do_op("mflo_div0", 5'd20, 32'd0, 32'd0);
      do_op("divovf", 5'd17, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("mflo_divovf", 5'd20, 32'd0, 32'd0);
      do_op("mfhi_divovf", 5'd19, 32'd0, 32'd0);

      // Overlap: independent ALU work proceeds while the unit iterates
      do_op("multu", 5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int i = 0; i < 5; i++) do_op("ovl_add", 5'd0, $urandom, $urandom);
      while (cyc < ready_cyc - 1) bubble();
      #3 check("busy_last", MdBusy, 1'b1);
      bubble();
      check("busy_done", MdBusy, 1'b0);
      do_op("mfhi_multu", 5'd19, 32'd0, 32'd0);
      do_op("mflo_multu", 5'd20, 32'd0, 32'd0);
      check("multu_vals", {hi_m, lo_m}, {32'hFFFF_FFFE, 32'd1});

      // Back-to-back MULT then DIV, then MTHI held behind a busy unit
      do_op("b2b_mult", 5'd15, $urandom, $urandom);
      do_op("b2b_div", 5'd17, $urandom, 32'd13);
      do_op("b2b_mflo", 5'd20, 32'd0, 32'd0);
      do_op("b2b_mfhi", 5'd19, 32'd0, 32'd0);
      do_op("mth_mult", 5'd15, $urandom, $urandom);
      do_op("mthi_busy", 5'd21, 32'h0000_ABCD, 32'd0);
      do_op("mthi_mfhi", 5'd19, 32'd0, 32'd0);
      do_op("mthi_mflo", 5'd20, 32'd0, 32'd0);

      // Random mul/div
      for (int i = 0; i < 6; i++) begin
         op = 5'($urandom_range(15, 18));
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         do_op("rand_md", op, $urandom, b);
         if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 40)) bubble();
         do_op("rand_mflo", 5'd20, 32'd0, 32'd0);
         do_op("rand_mfhi", 5'd19, 32'd0, 32'd0);
      end

      // Reset in the middle of a DIV
      do_op("rst_div", 5'd17, 32'd100, 32'd7);
      repeat (9) bubble();
      ALUControlE = 5'd19; RegWriteE = 1'b1;
      #4;
      check("rst_pre", {MdBusy, StallE}, 2'b11);
      reset = 1'b1;
      #1;
      check("rst_now", {MdBusy, StallE}, 2'b00);
      @(posedge clock); #1;
      reset = 1'b0;
      hi_m = 32'd0; lo_m = 32'd0; ready_cyc = 0;
      do_op("rst_mfhi", 5'd19, 32'd0, 32'd0);
      do_op("rst_mtlo", 5'd22, 32'h0000_0055, 32'd0);
      do_op("rst_mflo", 5'd20, 32'd0, 32'd0);
      check("rst_mflo_val", lo_m, 32'h0000_0055);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
